led_pwm_fader: RTL and testbench

Downstream stage of the 4-bit flow-light shifter. Consumes its one-hot LED pattern and drives the physical LED pins with PWM. On every channel change it ramps brightness smoothly up or down instead of switching hard, giving a cross-fading flow effect. One instance drives all four LEDs; each channel ramps independently.

---
 rtl/led_pwm_fader.sv | 100 ++++++++++
 tb/tb_led_pwm_fader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// Four-channel LED PWM driver with per-channel brightness fading.
// Each channel ramps its duty toward full or off whenever its one-hot target changes.
`timescale 1ns/1ps

module led_pwm_fader #(
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 3921,
   parameter int STEP     = 1
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       fade_en,
   input  logic [3:0] led_in,
   output logic [3:0] led_out,
   output logic       busy
);

   localparam int NUM_CH = 4;
   localparam int SW     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] PWM_LAST  = MAX - PWM_BITS'(1);
   localparam logic [PWM_BITS-1:0] STEP_D    = PWM_BITS'(STEP);
   localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS + 1)'(STEP);
   localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);

   logic [3:0]          tgt_reg;
   logic [PWM_BITS-1:0] pwm_cnt_reg;
   logic [PWM_BITS-1:0] pwm_cnt_next;
   logic [SW-1:0]       step_cnt_reg;
   logic [SW-1:0]       step_cnt_next;
   logic                tick;
   logic [PWM_BITS-1:0] duty_reg  [NUM_CH];
   logic [PWM_BITS-1:0] duty_next [NUM_CH];
   logic [3:0]          led_out_reg;
   logic [3:0]          led_out_next;
   logic                busy_reg;
   logic [3:0]          mismatch;

   // With STEP_DIV = 1 the timer is pinned at 0 and tick stays high.
   assign tick          = (step_cnt_reg == STEP_LAST);
   assign step_cnt_next = tick ? '0 : step_cnt_reg + SW'(1);

   // The PWM period is MAX clocks, so a duty of MAX never drops low.
   assign pwm_cnt_next = (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + PWM_BITS'(1);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [PWM_BITS:0]   sum_w;
         logic [PWM_BITS-1:0] target;
         logic [PWM_BITS-1:0] d_next;

         assign target = tgt_reg[gi] ? MAX : '0;
         assign sum_w  = {1'b0, duty_reg[gi]} + STEP_W;

         always_comb begin
            d_next = duty_reg[gi];
            if (!fade_en) begin
               d_next = target;
            end else if (tick) begin
               if (tgt_reg[gi]) begin
                  d_next = (sum_w > {1'b0, MAX}) ? MAX : sum_w[PWM_BITS-1:0];
               end else begin
                  d_next = (duty_reg[gi] >= STEP_D) ? duty_reg[gi] - STEP_D : '0;
               end
            end
         end

         assign duty_next[gi]    = d_next;
         assign led_out_next[gi] = (duty_reg[gi] > pwm_cnt_reg);
         assign mismatch[gi]     = (duty_reg[gi] != target);
      end
   endgenerate

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tgt_reg      <= '0;
         pwm_cnt_reg  <= '0;
         step_cnt_reg <= '0;
         led_out_reg  <= '0;
         busy_reg     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_reg[i] <= '0;
         end
      end else begin
         tgt_reg      <= led_in;
         pwm_cnt_reg  <= pwm_cnt_next;
         step_cnt_reg <= step_cnt_next;
         led_out_reg  <= led_out_next;
         busy_reg     <= |mismatch;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_reg[i] <= duty_next[i];
         end
      end
   end

   assign led_out = led_out_reg;
   assign busy    = busy_reg;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Scoreboard bench for led_pwm_fader: expected duty-change events are queued per channel
// and a negedge monitor pops one whenever a channel's duty moves.
`timescale 1ns/1ps

module tb_led_pwm_fader;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       fade_en;
   logic [3:0] led_in;
   logic [3:0] led_in_s;
   logic [3:0] led_out;
   logic [3:0] led_out_s;
   logic       busy;
   logic       busy_s;

   int checks   = 0;
   int failures = 0;

   // keys 0..3: main instance channels, keys 4..7: slow STEP=4 instance channels
   int exp_q [8][$];

   always #5 sys_clk = ~sys_clk;

   led_pwm_fader #(.PWM_BITS(4), .STEP_DIV(4), .STEP(1)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .fade_en   (fade_en),
      .led_in    (led_in),
      .led_out   (led_out),
      .busy      (busy)
   );

   // Long step interval so a duty holds still across a whole PWM period.
   led_pwm_fader #(.PWM_BITS(4), .STEP_DIV(32), .STEP(4)) dut_s (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .fade_en   (fade_en),
      .led_in    (led_in_s),
      .led_out   (led_out_s),
      .busy      (busy_s)
   );

   function automatic int get_duty(input int k);
      logic [1:0] c;
      c = k[1:0];
      if (k < 4) return int'(dut.duty_reg[c]);
      else       return int'(dut_s.duty_reg[c]);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic push_ramp(input int k, input int from, input int to);
      if (from <= to) for (int v = from; v <= to; v++) exp_q[k].push_back(v);
      else            for (int v = from; v >= to; v--) exp_q[k].push_back(v);
   endtask

   task automatic wait_duty(input int k, input int v, input int budget);
      int n;
      n = 0;
      while (get_duty(k) != v && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      if (get_duty(k) != v) begin
         checks++;
         failures++;
         $display("FAIL wait_duty key=%0d: got %0d, expected %0d within %0d cycles", k, get_duty(k), v, budget);
      end
   endtask

   // Count high cycles of one led_out bit over one 15-cycle PWM period.
   task automatic count_high(input int w, input int ch, output int cnt);
      cnt = 0;
      repeat (15) begin
         @(negedge sys_clk);
         if (w == 0) cnt += int'(led_out[ch]);
         else        cnt += int'(led_out_s[ch]);
      end
   endtask

   // Monitor: every duty movement must match the next queued expectation.
   initial begin
      int prev [8];
      int cur;
      int e;
      for (int k = 0; k < 8; k++) prev[k] = 0;
      forever begin
         @(negedge sys_clk);
         for (int k = 0; k < 8; k++) begin
            cur = get_duty(k);
            if (cur != prev[k]) begin
               if (exp_q[k].size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL duty_unexpected key=%0d: got %0d, expected hold at %0d", k, cur, prev[k]);
               end else begin
                  e = exp_q[k].pop_front();
                  check($sformatf("duty_key%0d", k), cur, e);
                  $display("duty event key=%0d value=%0d expected=%0d", k, cur, e);
               end
               prev[k] = cur;
            end
         end
      end
   end

   initial begin
      int cnt;
      sys_rst_n = 1'b0;
      fade_en   = 1'b1;
      led_in    = 4'hF;
      led_in_s  = 4'h0;

      // reset held with all targets lit: nothing may light or report busy
      for (int i = 0; i < 5; i++) begin
         @(negedge sys_clk);
         check("reset_outputs", {27'd0, busy, led_out}, 0);
      end

      // release: all four channels ramp 1..15 together
      for (int k = 0; k < 4; k++) push_ramp(k, 1, 15);
      sys_rst_n = 1'b1;
      wait_duty(0, 15, 120);
      check("busy_at_last_step", int'(busy), 1);
      cyc(2);
      check("busy_after_ramp", int'(busy), 0);
      cnt = 0;
      repeat (15) begin
         @(negedge sys_clk);
         if (led_out == 4'hF) cnt++;
      end
      check("all_on_constant", cnt, 15);

      // ramp all down to 0
      for (int k = 0; k < 4; k++) push_ramp(k, 14, 0);
      led_in = 4'h0;
      wait_duty(0, 0, 120);
      cyc(3);
      check("busy_after_rampdown", int'(busy), 0);

      // single channel ramp to 5, others stay dark
      push_ramp(0, 1, 5);
      led_in = 4'b0001;
      wait_duty(0, 5, 60);
      check("others_dark", int'(led_out[3:1]), 0);

      // hand over to ch1: ch0 fades out while ch1 climbs to 8, then reverse ch1
      push_ramp(0, 4, 0);
      push_ramp(1, 1, 8);
      led_in = 4'b0010;
      wait_duty(1, 8, 60);
      push_ramp(1, 7, 0);
      led_in = 4'b0000;
      wait_duty(1, 0, 60);
      check("ch0_done", get_duty(0), 0);

      // bypass: duty jumps two cycles after the led_in edge
      fade_en = 1'b0;
      cyc(2);
      exp_q[2].push_back(15);
      exp_q[2].push_back(0);
      led_in = 4'b0100;
      @(negedge sys_clk);
      check("bypass_up_cycle1", get_duty(2), 0);
      @(negedge sys_clk);
      check("bypass_up_cycle2", get_duty(2), 15);
      count_high(0, 2, cnt);
      check("bypass_led2_on", cnt, 15);
      led_in = 4'b0000;
      @(negedge sys_clk);
      check("bypass_down_cycle1", get_duty(2), 15);
      @(negedge sys_clk);
      check("bypass_down_cycle2", get_duty(2), 0);
      count_high(0, 2, cnt);
      check("bypass_led2_off", cnt, 0);
      fade_en = 1'b1;
      cyc(2);

      // asynchronous reset in the middle of a ch3 ramp
      push_ramp(3, 1, 9);
      led_in = 4'b1000;
      wait_duty(3, 9, 60);
      exp_q[3].push_back(0);
      #1 sys_rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {27'd0, busy, led_out}, 0);
      check("async_reset_duty", get_duty(3), 0);
      @(negedge sys_clk);
      push_ramp(3, 1, 3);
      sys_rst_n = 1'b1;
      wait_duty(3, 3, 40);
      push_ramp(3, 2, 0);
      led_in = 4'b0000;
      wait_duty(3, 0, 40);

      // STEP=4 saturation, with exact PWM high counts at each plateau
      exp_q[4].push_back(4);
      exp_q[4].push_back(8);
      exp_q[4].push_back(12);
      exp_q[4].push_back(15);
      led_in_s = 4'b0001;
      for (int v = 4; v <= 16; v += 4) begin
         wait_duty(4, (v > 15) ? 15 : v, 80);
         @(negedge sys_clk);
         count_high(1, 0, cnt);
         check($sformatf("pwm_high_d%0d", (v > 15) ? 15 : v), cnt, (v > 15) ? 15 : v);
      end
      cyc(40);
      check("saturated_hold", get_duty(4), 15);
      exp_q[4].push_back(11);
      exp_q[4].push_back(7);
      exp_q[4].push_back(3);
      exp_q[4].push_back(0);
      led_in_s = 4'b0000;
      wait_duty(4, 3, 150);
      @(negedge sys_clk);
      count_high(1, 0, cnt);
      check("pwm_high_d3", cnt, 3);
      wait_duty(4, 0, 80);
      cyc(40);
      check("floor_hold", get_duty(4), 0);

      // every queued expectation must have been consumed
      for (int k = 0; k < 8; k++) check($sformatf("queue_left_key%0d", k), exp_q[k].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
